// File: rtl/nios2_debug_ocimem_ctrl.sv
// Debug-RAM / monitor-CSR controller on the system clock.
// Consumes the JTAG ocimem command strobes (A: set address + read, no_action A:
// step address + read, B: write + step address) and shares the same single-port
// RAM and 2-bit monitor CSR with the CPU through an Avalon-MM slave.
//
// state      | meaning
// -----------+------------------------------------------------------------
// ST_IDLE    | no CPU read in flight; reads and writes are accepted here
// ST_RD_WAIT | read issued, source word buffered; load avs_readdata
// ST_RD_DONE | avs_readdata valid, waitrequest low for one cycle
//
// The JTAG side owns the RAM port in the cycle after each strobe (jtag_busy).
// CPU RAM accesses stall while JTAG owns the port; CSR accesses never stall.
module nios2_debug_ocimem_ctrl #(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [37:0]       jdo,
  input  logic              take_action_ocimem_a,
  input  logic              take_no_action_ocimem_a,
  input  logic              take_action_ocimem_b,
  input  logic [ADDR_W:0]   avs_address,
  input  logic              avs_read,
  input  logic              avs_write,
  input  logic [31:0]       avs_writedata,
  input  logic [3:0]        avs_byteenable,
  output logic [31:0]       avs_readdata,
  output logic              avs_waitrequest,
  output logic [31:0]       MonDReg,
  output logic [ADDR_W-1:0] MonAReg,
  output logic              monitor_ready,
  output logic              monitor_error
);

  localparam int DEPTH = 1 << ADDR_W;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RD_WAIT = 2'd1,
    ST_RD_DONE = 2'd2
  } cpu_state_e;

  // JTAG command decode
  logic              sel_a;
  logic              sel_n;
  logic              sel_b;
  logic              flag_clr;
  logic [ADDR_W-1:0] jdo_addr;

  // JTAG pipeline slot (cycle T+1 after a strobe)
  logic              jrd_q;
  logic              jwr_q;
  logic [ADDR_W-1:0] jwaddr_q;
  logic [31:0]       jwdata_q;
  logic              jtag_busy;

  // Monitor address / data registers
  logic [ADDR_W-1:0] mon_a_q;
  logic [ADDR_W-1:0] mon_a_d;
  logic [31:0]       mon_d_q;

  // Monitor CSR
  logic              rdy_q;
  logic              rdy_d;
  logic              err_q;
  logic              err_d;
  logic [31:0]       csr_word;

  // CPU side
  cpu_state_e        state_q;
  cpu_state_e        state_d;
  logic              cpu_csr;
  logic [ADDR_W-1:0] cpu_addr;
  logic              cpu_wait;
  logic              cpu_rd_issue;
  logic              cpu_rd_capture;
  logic              cpu_wr_go;
  logic [31:0]       rdbuf_q;
  logic [31:0]       readdata_q;

  // Shared RAM port
  logic [31:0]       mem [0:DEPTH-1];
  logic [ADDR_W-1:0] ram_addr;
  logic              ram_we;
  logic [3:0]        ram_be;
  logic [31:0]       ram_wdata;
  logic [31:0]       ram_rword;

  logic              unused_jdo;

  assign unused_jdo = ^{jdo[37:36], jdo[2:0]};

  // B beats A beats no_action when strobes collide
  assign sel_b    = take_action_ocimem_b;
  assign sel_a    = take_action_ocimem_a & ~take_action_ocimem_b;
  assign sel_n    = take_no_action_ocimem_a & ~take_action_ocimem_a & ~take_action_ocimem_b;
  assign jdo_addr = jdo[ADDR_W+16:17];
  assign flag_clr = sel_a & jdo[35];

  assign jtag_busy = jrd_q | jwr_q;

  assign cpu_csr  = avs_address[ADDR_W];
  assign cpu_addr = avs_address[ADDR_W-1:0];
  assign csr_word = {30'b0, err_q, rdy_q};

  // Monitor address next value: load on A, step (with natural wrap) on B / no_action
  always_comb begin
    mon_a_d = mon_a_q;
    if (sel_a) begin
      mon_a_d = jdo_addr;
    end else if (sel_b || sel_n) begin
      mon_a_d = mon_a_q + ADDR_W'(1);
    end
  end

  // CPU FSM next state and handshake; JTAG RAM ownership stalls RAM-targeted accesses
  always_comb begin
    state_d        = state_q;
    cpu_wait       = 1'b0;
    cpu_rd_issue   = 1'b0;
    cpu_rd_capture = 1'b0;
    cpu_wr_go      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (avs_read) begin
          cpu_wait = 1'b1;
          if (cpu_csr || !jtag_busy) begin
            cpu_rd_issue = 1'b1;
            state_d      = ST_RD_WAIT;
          end
        end else if (avs_write) begin
          if (!cpu_csr && jtag_busy) begin
            cpu_wait = 1'b1;
          end else begin
            cpu_wr_go = ~reset;
          end
        end
      end
      ST_RD_WAIT: begin
        cpu_wait       = 1'b1;
        cpu_rd_capture = 1'b1;
        state_d        = ST_RD_DONE;
      end
      ST_RD_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Flag clear from JTAG overrides a CPU CSR write in the same cycle
  always_comb begin
    rdy_d = rdy_q;
    err_d = err_q;
    if (flag_clr) begin
      rdy_d = 1'b0;
      err_d = 1'b0;
    end else if (cpu_wr_go && cpu_csr && avs_byteenable[0]) begin
      rdy_d = avs_writedata[0];
      err_d = avs_writedata[1];
    end
  end

  // RAM port mux: a JTAG slot always wins, otherwise the CPU address drives the port
  always_comb begin
    ram_addr  = cpu_addr;
    ram_we    = cpu_wr_go & ~cpu_csr;
    ram_be    = avs_byteenable;
    ram_wdata = avs_writedata;
    if (jwr_q) begin
      ram_addr  = jwaddr_q;
      ram_we    = 1'b1;
      ram_be    = 4'hF;
      ram_wdata = jwdata_q;
    end else if (jrd_q) begin
      ram_addr = mon_a_q;
      ram_we   = 1'b0;
    end
  end

  assign ram_rword = mem[ram_addr];

  // Debug RAM byte-lane writes; contents deliberately survive reset
  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (ram_we && ram_be[i]) begin
        mem[ram_addr][8*i +: 8] <= ram_wdata[8*i +: 8];
      end
    end
  end

  // JTAG pipeline slot, monitor address and monitor data registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      jrd_q    <= 1'b0;
      jwr_q    <= 1'b0;
      jwaddr_q <= '0;
      jwdata_q <= '0;
      mon_a_q  <= '0;
      mon_d_q  <= '0;
    end else begin
      jrd_q    <= sel_a | sel_n;
      jwr_q    <= sel_b;
      jwaddr_q <= mon_a_q;
      jwdata_q <= jdo[34:3];
      mon_a_q  <= mon_a_d;
      if (jrd_q) begin
        mon_d_q <= ram_rword;
      end
    end
  end

  // Monitor CSR flags
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rdy_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      rdy_q <= rdy_d;
      err_q <= err_d;
    end
  end

  // CPU FSM state, read buffer (filled on issue) and Avalon read data (filled in RD_WAIT)
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      rdbuf_q    <= '0;
      readdata_q <= '0;
    end else begin
      state_q <= state_d;
      if (cpu_rd_issue) begin
        rdbuf_q <= cpu_csr ? csr_word : ram_rword;
      end
      if (cpu_rd_capture) begin
        readdata_q <= rdbuf_q;
      end
    end
  end

  assign avs_waitrequest = cpu_wait & ~reset;
  assign avs_readdata    = readdata_q;
  assign MonDReg         = mon_d_q;
  assign MonAReg         = mon_a_q;
  assign monitor_ready   = rdy_q;
  assign monitor_error   = err_q;

endmodule
